// File: rtl/fdiv_pkg.sv
// rtl/fdiv_pkg.sv - shared types and constants for the single-precision divider
package fdiv_pkg;

   typedef enum logic [1:0] {IDLE, PREP, DIV, RND} state_t;

   localparam int NV = 4;
   localparam int DZ = 3;
   localparam int OF = 2;
   localparam int UF = 1;
   localparam int NX = 0;

   localparam logic [31:0] CANON_NAN = 32'hffc00000;
   localparam logic [31:0] QNAN_BIT  = 32'h00400000;
   localparam int          QBITS     = 26;
   localparam int          BIAS      = 127;

endpackage

// File: rtl/fdiv_if.sv
// rtl/fdiv_if.sv - request/result handshake between a requester and the divider
interface fdiv_if;
   logic        req;
   logic [31:0] x;
   logic [31:0] y;
   logic        busy;
   logic        valid;
   logic [31:0] rslt;
   logic [4:0]  flag;

   modport master (output req, x, y, input busy, valid, rslt, flag);
   modport slave  (input req, x, y, output busy, valid, rslt, flag);
endinterface

// File: rtl/fdiv_prenorm.sv
// rtl/fdiv_prenorm.sv - expand an IEEE single operand to a 24-bit mantissa with hidden one
module fdiv_prenorm (
   input  logic [7:0]        bexp,
   input  logic [22:0]       frac,
   output logic [23:0]       mant,
   output logic signed [9:0] exp_n
);

   logic [4:0] lz;

   always_comb begin
      lz = 5'd0;
      // highest set fraction bit wins; the shift brings it up to the hidden-bit position
      for (int i = 0; i < 23; i++) begin
         if (frac[i]) lz = 5'(23 - i);
      end
      if (bexp == 8'd0) begin
         mant  = {1'b0, frac} << lz;
         exp_n = 10'sd1 - $signed({5'd0, lz});
      end else begin
         mant  = {1'b1, frac};
         exp_n = $signed({2'b00, bexp});
      end
   end

endmodule

// File: rtl/fdiv.sv
// rtl/fdiv.sv - multi-cycle radix-2 restoring IEEE single divider, RNE, fixed 28-cycle latency
module fdiv
   import fdiv_pkg::*;
(
   input  logic  clk,
   input  logic  reset,
   fdiv_if.slave bus
);

   state_t            state, state_n;
   logic [31:0]       xr, yr;
   logic [23:0]       my;
   logic [24:0]       rem;
   logic [QBITS-1:0]  q;
   logic [4:0]        cnt;
   logic signed [9:0] eq;
   logic [31:0]       rslt_r, rslt_n;
   logic [4:0]        flag_r, flag_n;
   logic              valid_r;

   logic [23:0]       mx_p, my_p;
   logic signed [9:0] ex_p, ey_p;
   logic [25:0]       trial;
   logic [24:0]       rem_sel;

   fdiv_prenorm u_pre_x (.bexp(xr[30:23]), .frac(xr[22:0]), .mant(mx_p), .exp_n(ex_p));
   fdiv_prenorm u_pre_y (.bexp(yr[30:23]), .frac(yr[22:0]), .mant(my_p), .exp_n(ey_p));

   // compare before shifting so the first quotient bit carries weight 1 (ratio in [0.5,2))
   assign trial   = {1'b0, rem} - {2'b00, my};
   assign rem_sel = trial[25] ? rem : trial[24:0];

   assign bus.busy  = (state != IDLE);
   assign bus.valid = valid_r;
   assign bus.rslt  = rslt_r;
   assign bus.flag  = flag_r;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE: if (bus.req) state_n = PREP;
         PREP: state_n = DIV;
         DIV:  if (cnt == 5'(QBITS - 1)) state_n = RND;
         RND:  state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         xr      <= '0;
         yr      <= '0;
         my      <= '0;
         rem     <= '0;
         q       <= '0;
         cnt     <= '0;
         eq      <= '0;
         rslt_r  <= '0;
         flag_r  <= '0;
         valid_r <= 1'b0;
      end else begin
         valid_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.req) begin
                  xr <= bus.x;
                  yr <= bus.y;
               end
            end
            PREP: begin
               rem <= {1'b0, mx_p};
               my  <= my_p;
               eq  <= ex_p - ey_p + 10'(BIAS);
               cnt <= '0;
               q   <= '0;
            end
            DIV: begin
               q   <= {q[QBITS-2:0], ~trial[25]};
               rem <= rem_sel << 1;
               cnt <= cnt + 5'd1;
            end
            RND: begin
               rslt_r  <= rslt_n;
               flag_r  <= flag_n;
               valid_r <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   logic x_nan, y_nan, x_snan, y_snan, x_inf, y_inf, x_zero, y_zero;
   assign x_nan  = (xr[30:23] == 8'hff) && (xr[22:0] != '0);
   assign y_nan  = (yr[30:23] == 8'hff) && (yr[22:0] != '0);
   assign x_snan = x_nan && !xr[22];
   assign y_snan = y_nan && !yr[22];
   assign x_inf  = (xr[30:23] == 8'hff) && (xr[22:0] == '0);
   assign y_inf  = (yr[30:23] == 8'hff) && (yr[22:0] == '0);
   assign x_zero = (xr[30:0] == '0);
   assign y_zero = (yr[30:0] == '0);

   logic              sign, q_norm, tiny, lost, guard, sticky, rnd_up, inexact;
   logic [25:0]       m26, m_sh;
   logic signed [9:0] eq_n, sh_full, e_fin;
   logic [4:0]        sh;
   logic [23:0]       mant;
   logic [24:0]       sum;

   always_comb begin
      sign    = xr[31] ^ yr[31];
      q_norm  = q[QBITS-1];
      m26     = q_norm ? q : {q[QBITS-2:0], 1'b0};
      eq_n    = q_norm ? eq : eq - 10'sd1;
      tiny    = (eq_n <= 10'sd0);
      sh_full = 10'sd1 - eq_n;
      sh      = 5'd0;
      if (tiny) sh = (sh_full > 10'sd26) ? 5'd26 : sh_full[4:0];
      m_sh    = m26 >> sh;
      lost    = |(m26 & ((26'd1 << sh) - 26'd1));
      guard   = m_sh[1];
      sticky  = m_sh[0] | lost | (|rem);
      mant    = m_sh[25:2];
      rnd_up  = guard & (sticky | mant[0]);
      sum     = {1'b0, mant} + {24'd0, rnd_up};
      inexact = guard | sticky;
      // a subnormal that rounds up into bit 23 is promoted to exponent 1
      e_fin   = tiny ? $signed({9'd0, sum[23]}) : eq_n + $signed({9'd0, sum[24]});

      flag_n = '0;
      if (!tiny && e_fin >= 10'sd255) begin
         rslt_n     = {sign, 8'hff, 23'd0};
         flag_n[OF] = 1'b1;
         flag_n[NX] = 1'b1;
      end else begin
         rslt_n     = {sign, e_fin[7:0], sum[22:0]};
         flag_n[NX] = inexact;
         flag_n[UF] = inexact && tiny && !sum[23];
      end

      if (x_nan) begin
         rslt_n     = xr | QNAN_BIT;
         flag_n     = '0;
         flag_n[NV] = x_snan | y_snan;
      end else if (y_nan) begin
         rslt_n     = yr | QNAN_BIT;
         flag_n     = '0;
         flag_n[NV] = y_snan;
      end else if ((x_zero && y_zero) || (x_inf && y_inf)) begin
         rslt_n     = CANON_NAN;
         flag_n     = '0;
         flag_n[NV] = 1'b1;
      end else if (x_inf) begin
         rslt_n = {sign, 8'hff, 23'd0};
         flag_n = '0;
      end else if (y_zero) begin
         rslt_n     = {sign, 8'hff, 23'd0};
         flag_n     = '0;
         flag_n[DZ] = 1'b1;
      end else if (x_zero || y_inf) begin
         rslt_n = {sign, 31'd0};
         flag_n = '0;
      end
   end

endmodule

// File: tb/tb_fdiv.sv
// tb/tb_fdiv.sv - scoreboard bench for fdiv: directed vectors, latency, ignored req and reset abort
module tb_fdiv;

   logic clk;
   logic reset;
   fdiv_if bus ();

   fdiv dut (.clk(clk), .reset(reset), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic [36:0] exp_q[$];
   time         t_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, want);
      end
   endtask

   // monitor: every valid pulse is matched against the oldest expectation
   always @(negedge clk) begin
      if (reset && bus.valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_valid", 32'd1, 32'd0);
         end else begin
            logic [36:0] e;
            time t0;
            e  = exp_q.pop_front();
            t0 = t_q.pop_front();
            chk("rslt", bus.rslt, e[36:5]);
            chk("flag", {27'd0, bus.flag}, {27'd0, e[4:0]});
            chk("latency", 32'($time - t0), 32'd285);
            chk("busy_at_valid", {31'd0, bus.busy}, 32'd0);
         end
      end
   end

   task automatic issue(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic [4:0] ef, input bit expect_res);
      int n = 0;
      @(negedge clk);
      while (bus.busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (bus.busy) chk("idle_timeout", 32'd1, 32'd0);
      bus.x   = a;
      bus.y   = b;
      bus.req = 1'b1;
      if (expect_res) exp_q.push_back({er, ef});
      @(posedge clk);
      if (expect_res) t_q.push_back($time);
      #1 bus.req = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain_left", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset   = 1'b0;
      bus.req = 1'b0;
      bus.x   = '0;
      bus.y   = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy",  {31'd0, bus.busy},  32'd0);
      chk("rst_valid", {31'd0, bus.valid}, 32'd0);
      chk("rst_rslt",  bus.rslt,           32'd0);
      chk("rst_flag",  {27'd0, bus.flag},  32'd0);
      reset = 1'b1;

      issue(32'h3f800000, 32'h40400000, 32'h3eaaaaab, 5'h01, 1'b1);
      issue(32'h40c00000, 32'h40000000, 32'h40400000, 5'h00, 1'b1);
      issue(32'h3f800000, 32'h3f800000, 32'h3f800000, 5'h00, 1'b1);
      issue(32'h3f800000, 32'h00000000, 32'h7f800000, 5'h08, 1'b1);
      issue(32'h00000000, 32'h00000000, 32'hffc00000, 5'h10, 1'b1);
      issue(32'h7f800001, 32'h3f800000, 32'h7fc00001, 5'h10, 1'b1);
      issue(32'h7f7fffff, 32'h3f000000, 32'h7f800000, 5'h05, 1'b1);
      issue(32'h80800000, 32'h40000000, 32'h80400000, 5'h00, 1'b1);
      issue(32'h00800001, 32'h40000000, 32'h00400000, 5'h03, 1'b1);
      issue(32'h00000001, 32'h3f000000, 32'h00000002, 5'h00, 1'b1);
      drain();

      // a req while busy must be dropped without disturbing the running divide
      issue(32'h3f800000, 32'h40400000, 32'h3eaaaaab, 5'h01, 1'b1);
      repeat (5) @(negedge clk);
      bus.x   = 32'h40000000;
      bus.y   = 32'h3f800000;
      bus.req = 1'b1;
      @(posedge clk);
      #1 bus.req = 1'b0;
      drain();

      issue(32'h3f800000, 32'h40400000, 32'h0, 5'h0, 1'b0);
      repeat (10) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("abort_busy",  {31'd0, bus.busy},  32'd0);
      chk("abort_valid", {31'd0, bus.valid}, 32'd0);
      chk("abort_rslt",  bus.rslt,           32'd0);
      chk("abort_flag",  {27'd0, bus.flag},  32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (40) @(negedge clk);
      chk("post_abort_rslt", bus.rslt, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
